sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
Sequences 32-bit load/store requests from the ARM memory stage onto the 16-bit external SRAM (64-entry behavioural model, 18-bit halfword address).
- Each word access is split into two halfword phases: low half at even halfword address, high half at address+1.
- Each phase is held for a fixed number of wait cycles.
- `ready` stalls (freezes) the pipeline until the word transfer completes.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM halfword 0; subtracted from every request address.
- WAIT_CYCLES, 5: clock cycles per halfword phase; legal range 2..15.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  store request, level, held by requester until ready.
- rd_en  in  1  load request, level, held by requester until ready.
- address  in  32  byte address; bits [1:0] ignored.
- wdata  in  32  store data.
- rdata  out  32  load data; valid while ready=1 in DONE after a read.
- ready  out  1  0 = stall requester; 1 = no request pending or current request complete.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_AW  SRAM halfword address.
- SRAM_UB_N  out  1  tied 0.
- SRAM_LB_N  out  1  tied 0.
- SRAM_WE_N  out  1  write enable, active-low.
- SRAM_CE_N  out  1  tied 0.
- SRAM_OE_N  out  1  tied 0.

Behaviour:
- Reset:
  - state=IDLE, counter=0, rdata=0, SRAM_WE_N=1, SRAM_ADDR=0.
  - SRAM_DQ released (high-Z).
  - Asynchronous; aborts any in-flight access with no partial-completion guarantee.
- Address mapping:
  - off = address - ADDR_BASE, 32-bit modular.
  - base_ha = {off[SRAM_AW:2], 1'b0}.
  - High half at base_ha+1; no range check, upper bits truncated (wrap-around).
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- IDLE:
  - wr_en=1 → latch address/wdata, go WR_LO.
  - else rd_en=1 → latch address, go RD_LO.
  - wr_en and rd_en both 1 → write wins.
- Phase states: counter counts 0..WAIT_CYCLES-1; on WAIT_CYCLES-1, reset counter and advance LO→HI→DONE.
- WR_LO / WR_HI:
  - SRAM_WE_N=0.
  - SRAM_DQ driven with wdata[15:0] (LO) or wdata[31:16] (HI).
  - SRAM_ADDR=base_ha (LO) or base_ha+1 (HI).
- RD_LO / RD_HI:
  - SRAM_WE_N=1, SRAM_DQ high-Z, same addresses as writes.
  - SRAM_DQ sampled into rdata[15:0] (LO) or rdata[31:16] (HI) on the last counter cycle of the phase.
  - WAIT_CYCLES>=2 covers the SRAM's one-cycle registered read.
- DONE:
  - ready=1 for exactly one cycle, then IDLE unconditionally.
  - A request still asserted is treated as a new request from IDLE.
- ready (combinational):
  - 1 in DONE.
  - 1 in IDLE with wr_en=rd_en=0.
  - 0 otherwise, including the IDLE cycle in which a request first appears.
- Latency: request seen in IDLE at cycle 0 → ready=1 in cycle 2*WAIT_CYCLES+1 (11 at default).
- Mid-operation request changes: latched op/address/data are used; changes to inputs are ignored until IDLE.
- rdata: holds its value between reads; unchanged by writes.
- SRAM_WE_N changes only on clock edges; never low outside WR_LO/WR_HI.

Optional Feature:
SRAM_CTRL_STATS_EN
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments by 1 on entry to DONE for its op type.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Write then read back: wr_en, address=1024, wdata=32'hDEADBEEF.
  - Halfword 0=16'hBEEF, halfword 1=16'hDEAD.
  - Then rd_en at 1024 → rdata=32'hDEADBEEF, ready=1 exactly at cycle 11.
- Address mapping: wr address=1036, wdata=32'h12345678 → SRAM_ADDR 6 written 16'h5678, SRAM_ADDR 7 written 16'h1234.
- Simultaneous request: wr_en=rd_en=1, address=1028, wdata=32'hA5A5_0F0F.
  - Write performed; rdata unchanged from previous value.
- Back-to-back: hold rd_en across DONE for addresses 1024 then 1028.
  - Two reads complete, ready pulses once per access, 12 cycles apart.
- Reset mid-operation: assert rst during cycle 3 of WR_LO.
  - ready=1 and SRAM_WE_N=1 immediately; SRAM_DQ=Z; rdata=0.
  - Next request completes normally.
- SRAM_CTRL_STATS_EN: 3 writes + 2 reads → wr_count=3, rd_count=2; rst → both 0.

Source files
------------

// File: rtl/sram_ctrl_if.sv
//------------------------------------------------------------------------------
// sram_ctrl_if : requester-side load/store handshake of the SRAM controller.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sram_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output wr_en, output rd_en, output address, output wdata,
                    input rdata, input ready);
    modport slave  (input wr_en, input rd_en, input address, input wdata,
                    output rdata, output ready);
endinterface

`default_nettype wire

// File: rtl/sram_ctrl.sv
//------------------------------------------------------------------------------
// sram_ctrl : splits 32-bit loads/stores into two timed 16-bit SRAM phases.
// Optional macro SRAM_CTRL_STATS_EN adds saturating rd_count/wr_count outputs.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sram_ctrl #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 5,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_if.slave         bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [3:0] C_LAST = 4'(WAIT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           counter_q, counter_d;
    logic [SRAM_AW-1:0]   base_q, base_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic                 we_n_q, we_n_d;
    logic [15:0]          dq_out_q, dq_out_d;
    logic [SRAM_AW:0]     off_w;
    logic [SRAM_AW-1:0]   base_ha_w;
    logic                 last_w;

    // Halfword index of the low half: drop the byte offset, force it even.
    assign off_w     = (SRAM_AW+1)'(bus.address - 32'(ADDR_BASE));
    assign base_ha_w = SRAM_AW'(off_w >> 1) & ~SRAM_AW'(1);
    assign last_w    = (counter_q == C_LAST);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                counter_d = 4'd0;
                if (bus.wr_en) begin
                    state_d = WR_LO;
                    base_d  = base_ha_w;
                    wdata_d = bus.wdata;
                end else if (bus.rd_en) begin
                    state_d = RD_LO;
                    base_d  = base_ha_w;
                end
            end
            WR_LO, WR_HI, RD_LO, RD_HI: begin
                counter_d = counter_q + 4'd1;
                if (last_w) begin
                    counter_d = 4'd0;
                    case (state_q)
                        WR_LO:   state_d = WR_HI;
                        RD_LO:   state_d = RD_HI;
                        default: state_d = DONE;
                    endcase
                    if (state_q == RD_LO) rdata_d[15:0]  = SRAM_DQ;
                    if (state_q == RD_HI) rdata_d[31:16] = SRAM_DQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin outputs are registered from the next state so they only move on edges.
        we_n_d      = !(state_d == WR_LO || state_d == WR_HI);
        dq_out_d    = (state_d == WR_HI) ? wdata_d[31:16] : wdata_d[15:0];
        sram_addr_d = sram_addr_q;
        if (state_d == WR_LO || state_d == RD_LO) sram_addr_d = base_d;
        if (state_d == WR_HI || state_d == RD_HI) sram_addr_d = base_d + SRAM_AW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            counter_q   <= 4'd0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_out_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign SRAM_DQ   = we_n_q ? 16'bz : dq_out_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign bus.rdata = rdata_q;
    assign bus.ready = (state_q == DONE) ||
                       (state_q == IDLE && !bus.wr_en && !bus.rd_en);

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == RD_HI && state_d == DONE && rd_count_q != 16'hFFFF)
            rd_count_d = rd_count_q + 16'd1;
        if (state_q == WR_HI && state_d == DONE && wr_count_q != 16'hFFFF)
            wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl.sv
//------------------------------------------------------------------------------
// tb_sram_ctrl : directed bench with a cycle-count reference model and SRAM model.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_ctrl;
    localparam int W    = 5;
    localparam int DONE = 2 * W + 1;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count, wr_count;
`endif

    int checks   = 0;
    int failures = 0;

    sram_ctrl_if bus_if ();

    sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n)
`ifdef SRAM_CTRL_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    // External SRAM: registered read, write whenever WE_N is low.
    logic [15:0] mem [64];
    logic [15:0] mem_rd_q = 16'd0;
    assign sram_dq = we_n ? mem_rd_q : 16'bz;
    always @(posedge clk) begin
        if (!we_n) mem[sram_addr[5:0]] <= sram_dq;
        mem_rd_q <= mem[sram_addr[5:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] hw_base(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return off[18:1] & 18'h3FFFE;
    endfunction

    // Reference model: counts cycles since the request was accepted.
    int          m_cnt;
    logic        m_wr;
    logic [17:0] m_base;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [15:0] ref_mem [64];
    int          m_rdc, m_wrc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= 0;
            m_rdata <= 32'd0;
            m_rdc   <= 0;
            m_wrc   <= 0;
        end else if (m_cnt == 0) begin
            if (bus_if.wr_en || bus_if.rd_en) begin
                m_cnt   <= 1;
                m_wr    <= bus_if.wr_en;
                m_base  <= hw_base(bus_if.address);
                m_wdata <= bus_if.wdata;
            end
        end else if (m_cnt == DONE) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 2 * W) begin
                if (m_wr) begin
                    ref_mem[m_base[5:0]]       <= m_wdata[15:0];
                    ref_mem[m_base[5:0] + 6'd1] <= m_wdata[31:16];
                    m_wrc <= (m_wrc == 65535) ? m_wrc : m_wrc + 1;
                end else begin
                    m_rdata <= {ref_mem[m_base[5:0] + 6'd1], ref_mem[m_base[5:0]]};
                    m_rdc   <= (m_rdc == 65535) ? m_rdc : m_rdc + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", 32'(bus_if.ready),
                32'((m_cnt == 0 && !bus_if.wr_en && !bus_if.rd_en) || m_cnt == DONE));
            chk("we_n", 32'(we_n), 32'(!(m_wr && m_cnt >= 1 && m_cnt <= 2 * W)));
            chk("tieoffs", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
            if (m_cnt >= 1 && m_cnt <= 2 * W)
                chk("sram_addr", 32'(sram_addr),
                    32'((m_cnt <= W) ? m_base : m_base + 18'd1));
            if (m_cnt == 0 || m_cnt == DONE)
                chk("rdata", bus_if.rdata, m_rdata);
`ifdef SRAM_CTRL_STATS_EN
            chk("wr_count", 32'(wr_count), 32'(m_wrc));
            chk("rd_count", 32'(rd_count), 32'(m_rdc));
`endif
        end
    end

    task automatic wait_ready(input bit scramble, output int n);
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (scramble && k == 2) begin
                bus_if.address = 32'hFFFF_FFFC;
                bus_if.wdata   = 32'h0;
            end
            if (bus_if.ready) begin
                n = k;
                break;
            end
        end
        if (n == 0) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic req(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input bit scramble, output int lat);
        @(posedge clk); #1;
        bus_if.wr_en   = wr;
        bus_if.rd_en   = rd;
        bus_if.address = a;
        bus_if.wdata   = d;
        wait_ready(scramble, lat);
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
    endtask

    int lat, lat2;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 16'd0;
            ref_mem[i] = 16'd0;
        end
        rst = 1'b1;
        bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0;
        bus_if.address = 32'd0; bus_if.wdata = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("reset_ready", 32'(bus_if.ready), 32'd1);
        chk("reset_we_n", 32'(we_n), 32'd1);
        chk("reset_addr", 32'(sram_addr), 32'd0);
        chk("reset_rdata", bus_if.rdata, 32'd0);
        #1 rst = 1'b0;

        // Write then read back.
        req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, lat);
        chk("wr_latency", 32'(lat), 32'd11);
        chk("mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("mem1", 32'(mem[1]), 32'h0000DEAD);
        req(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, lat);
        chk("rd_latency", 32'(lat), 32'd11);
        chk("rd_data", bus_if.rdata, 32'hDEADBEEF);

        // Address mapping, with inputs changed mid-operation.
        req(1'b1, 1'b0, 32'd1036, 32'h12345678, 1'b1, lat);
        chk("mem6", 32'(mem[6]), 32'h00005678);
        chk("mem7", 32'(mem[7]), 32'h00001234);

        // Simultaneous request: write wins, rdata untouched.
        req(1'b1, 1'b1, 32'd1028, 32'hA5A5_0F0F, 1'b0, lat);
        chk("mem2", 32'(mem[2]), 32'h00000F0F);
        chk("mem3", 32'(mem[3]), 32'h0000A5A5);
        chk("rdata_kept", bus_if.rdata, 32'hDEADBEEF);

        // Back-to-back reads with rd_en held across DONE.
        @(posedge clk); #1;
        bus_if.rd_en = 1'b1; bus_if.address = 32'd1024;
        wait_ready(1'b0, lat);
        chk("b2b_lat1", 32'(lat), 32'd11);
        chk("b2b_data1", bus_if.rdata, 32'hDEADBEEF);
        bus_if.address = 32'd1028;
        wait_ready(1'b0, lat2);
        chk("b2b_gap", 32'(lat2), 32'd12);
        chk("b2b_data2", bus_if.rdata, 32'hA5A50F0F);
        bus_if.rd_en = 1'b0;

        // Reset during the third cycle of WR_LO.
        @(posedge clk); #1;
        bus_if.wr_en = 1'b1; bus_if.address = 32'd1040; bus_if.wdata = 32'hCAFEF00D;
        @(posedge clk); @(posedge clk); @(posedge clk); #3;
        chk("mid_we_n", 32'(we_n), 32'd0);
        rst = 1'b1; bus_if.wr_en = 1'b0;
        #1;
        chk("rst_ready", 32'(bus_if.ready), 32'd1);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_rdata", bus_if.rdata, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_released", 32'(sram_dq), 32'(mem_rd_q));
        @(negedge clk); #1 rst = 1'b0;
        req(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, lat);
        chk("post_rst_lat", 32'(lat), 32'd11);
        chk("post_rst_data", bus_if.rdata, 32'hDEADBEEF);

        // Three writes and two reads from a clean reset.
        @(negedge clk); rst = 1'b1; @(negedge clk); #1 rst = 1'b0;
        req(1'b1, 1'b0, 32'd1048, 32'h11112222, 1'b0, lat);
        req(1'b1, 1'b0, 32'd1052, 32'h33334444, 1'b0, lat);
        req(1'b1, 1'b0, 32'd1056, 32'h55556666, 1'b0, lat);
        req(1'b0, 1'b1, 32'd1048, 32'd0, 1'b0, lat);
        chk("rd_1048", bus_if.rdata, 32'h11112222);
        req(1'b0, 1'b1, 32'd1052, 32'd0, 1'b0, lat);
        chk("rd_1052", bus_if.rdata, 32'h33334444);
`ifdef SRAM_CTRL_STATS_EN
        @(negedge clk);
        chk("stats_wr", 32'(wr_count), 32'd3);
        chk("stats_rd", 32'(rd_count), 32'd2);
        rst = 1'b1; #1;
        chk("stats_wr_rst", 32'(wr_count), 32'd0);
        chk("stats_rd_rst", 32'(rd_count), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
`endif
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
